// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for decode-stage branch resolution.
// Opcodes, REGIMM sub-ops, forward selects and FSM states.
package branch_resolve_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic {
    FWD_RF  = 1'b0,
    FWD_MEM = 1'b1
  } fwd_sel_e;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_WAIT = 1'b1
  } br_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_hazard.sv
// Per-operand RAW hazard check and forward select.
// Register $0 never hazards and is never forwarded.
module branch_hazard_detect
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int RA = 5
) (
  input  logic [RA-1:0] i_src,
  input  logic          i_use,
  input  logic          i_ex_wreg,
  input  logic [RA-1:0] i_ex_waddr,
  input  logic          i_mem_wreg,
  input  logic [RA-1:0] i_mem_waddr,
  input  logic          i_mem_load,
  input  logic          i_mem_ready,
  output logic          o_haz,
  output fwd_sel_e      o_fwd
);

  logic w_nz;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_mem_wait;

  assign w_nz       = (i_src != '0);
  assign w_ex_hit   = w_nz && i_ex_wreg
                   && (i_ex_waddr == i_src);
  assign w_mem_hit  = w_nz && i_mem_wreg
                   && (i_mem_waddr == i_src);
  assign w_mem_wait = w_mem_hit && i_mem_load
                   && !i_mem_ready;

  // EX producer outranks MEM; MEM load stalls until data is valid
  always_comb begin
    o_haz = i_use && (w_ex_hit || w_mem_wait);
    o_fwd = (w_mem_hit && !w_ex_hit) ? FWD_MEM : FWD_RF;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolve: stall, forward, redirect.
// Optional counters under BRANCH_RESOLVE_STATS_EN.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [5:0]    id_op,
  input  logic [4:0]    id_rt_f,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [DW-1:0] id_pc4,
  input  logic [15:0]   id_imm,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  input  logic          ex_wreg,
  input  logic [RA-1:0] ex_waddr,
  input  logic          mem_wreg,
  input  logic [RA-1:0] mem_waddr,
  input  logic          mem_load,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_result,
  input  logic          pipe_flush,
  input  logic          cmp_y,
  output logic [5:0]    cmp_op,
  output logic [4:0]    cmp_rt,
  output logic [DW-1:0] cmp_a,
  output logic [DW-1:0] cmp_b,
  output logic          stall_id,
  output logic          redirect_valid,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_taken,
  output logic [31:0]   stat_stalls,
`endif
  output logic [DW-1:0] redirect_target
);

  br_state_e     r_state;
  br_state_e     w_state_nxt;
  logic          r_redir_valid;
  logic [DW-1:0] r_redir_target;

  logic          w_is_br;
  logic          w_use_b;
  logic          w_haz_a;
  logic          w_haz_b;
  logic          w_haz;
  fwd_sel_e      w_fwd_a;
  fwd_sel_e      w_fwd_b;
  logic          w_stall;
  logic          w_resolve;
  logic          w_taken;
  logic [DW-1:0] w_target;

  // Decode branch class from opcode and REGIMM sub-op
  always_comb begin
    w_is_br = 1'b0;
    w_use_b = 1'b0;
    if (id_valid) begin
      unique case (1'b1)
        (id_op == OP_BEQ),
        (id_op == OP_BNE): begin
          w_is_br = 1'b1;
          w_use_b = 1'b1;
        end
        (id_op == OP_BLEZ),
        (id_op == OP_BGTZ): w_is_br = 1'b1;
        (id_op == OP_REGIMM):
          w_is_br = (id_rt_f inside
            {RT_BLTZ, RT_BGEZ,
             RT_BLTZAL, RT_BGEZAL});
        default: w_is_br = 1'b0;
      endcase
    end
  end

  branch_hazard_detect #(.RA(RA)) u_haz_rs (
    .i_src       (id_rs),
    .i_use       (1'b1),
    .i_ex_wreg   (ex_wreg),
    .i_ex_waddr  (ex_waddr),
    .i_mem_wreg  (mem_wreg),
    .i_mem_waddr (mem_waddr),
    .i_mem_load  (mem_load),
    .i_mem_ready (mem_ready),
    .o_haz       (w_haz_a),
    .o_fwd       (w_fwd_a)
  );

  branch_hazard_detect #(.RA(RA)) u_haz_rt (
    .i_src       (id_rt),
    .i_use       (w_use_b),
    .i_ex_wreg   (ex_wreg),
    .i_ex_waddr  (ex_waddr),
    .i_mem_wreg  (mem_wreg),
    .i_mem_waddr (mem_waddr),
    .i_mem_load  (mem_load),
    .i_mem_ready (mem_ready),
    .o_haz       (w_haz_b),
    .o_fwd       (w_fwd_b)
  );

  assign w_haz = w_haz_a || w_haz_b;

  assign w_target = id_pc4
    + {{(DW-18){id_imm[15]}}, id_imm, 2'b00};

  // Comparator inputs; non-branches get op 0 so the result is 0
  always_comb begin
    cmp_op = w_is_br ? id_op : 6'd0;
    cmp_rt = w_is_br ? id_rt_f : 5'd0;
    cmp_a  = (w_fwd_a == FWD_MEM) ? mem_result : rf_a;
    cmp_b  = (w_fwd_b == FWD_MEM) ? mem_result : rf_b;
  end

  // Next state, stall and resolve strobe
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    unique case (r_state)
      BR_IDLE: begin
        if (w_is_br) begin
          if (w_haz) begin
            w_stall     = 1'b1;
            w_state_nxt = BR_WAIT;
          end else begin
            w_resolve   = 1'b1;
          end
        end
      end
      BR_WAIT: begin
        if (!w_is_br) begin
          w_state_nxt = BR_IDLE;
        end else if (w_haz) begin
          w_stall     = 1'b1;
        end else begin
          w_resolve   = 1'b1;
          w_state_nxt = BR_IDLE;
        end
      end
      default: w_state_nxt = BR_IDLE;
    endcase
  end

  // Reset and flush suppress the stall immediately
  assign stall_id = w_stall && resetn && !pipe_flush;
  assign w_taken  = w_resolve && cmp_y;

  // State and redirect registers; flush beats a resolve
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= BR_IDLE;
      r_redir_valid  <= 1'b0;
      r_redir_target <= '0;
    end else if (pipe_flush) begin
      r_state        <= BR_IDLE;
      r_redir_valid  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_redir_valid  <= w_taken;
      if (w_taken) begin
        r_redir_target <= w_target;
      end
    end
  end

  assign redirect_valid  = r_redir_valid;
  assign redirect_target = r_redir_target;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] r_st_br;
  logic [31:0] r_st_tk;
  logic [31:0] r_st_sl;

  // Saturating counters; only reset clears them
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_st_br <= '0;
      r_st_tk <= '0;
      r_st_sl <= '0;
    end else begin
      if (w_resolve && !pipe_flush) begin
        r_st_br <= sat_inc(r_st_br);
      end
      if (w_taken && !pipe_flush) begin
        r_st_tk <= sat_inc(r_st_tk);
      end
      if (stall_id) begin
        r_st_sl <= sat_inc(r_st_sl);
      end
    end
  end

  assign stat_branches = r_st_br;
  assign stat_taken    = r_st_tk;
  assign stat_stalls   = r_st_sl;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl.
// Stats checks compile in with BRANCH_RESOLVE_STATS_EN.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_rt_f;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_pc4;
  logic [15:0] id_imm;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic        mem_load;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic        pipe_flush;
  logic        cmp_y;
  logic [5:0]  cmp_op;
  logic [4:0]  cmp_rt;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_stalls;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_ctrl #(.DW(32), .RA(5)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_valid        (id_valid),
    .id_op           (id_op),
    .id_rt_f         (id_rt_f),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_pc4          (id_pc4),
    .id_imm          (id_imm),
    .rf_a            (rf_a),
    .rf_b            (rf_b),
    .ex_wreg         (ex_wreg),
    .ex_waddr        (ex_waddr),
    .mem_wreg        (mem_wreg),
    .mem_waddr       (mem_waddr),
    .mem_load        (mem_load),
    .mem_ready       (mem_ready),
    .mem_result      (mem_result),
    .pipe_flush      (pipe_flush),
    .cmp_y           (cmp_y),
    .cmp_op          (cmp_op),
    .cmp_rt          (cmp_rt),
    .cmp_a           (cmp_a),
    .cmp_b           (cmp_b),
    .stall_id        (stall_id),
    .redirect_valid  (redirect_valid),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_branches   (stat_branches),
    .stat_taken      (stat_taken),
    .stat_stalls     (stat_stalls),
`endif
    .redirect_target (redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    id_valid   = 1'b0;
    id_op      = 6'd0;
    id_rt_f    = 5'd0;
    id_rs      = 5'd0;
    id_rt      = 5'd0;
    id_pc4     = 32'd0;
    id_imm     = 16'd0;
    rf_a       = 32'd0;
    rf_b       = 32'd0;
    ex_wreg    = 1'b0;
    ex_waddr   = 5'd0;
    mem_wreg   = 1'b0;
    mem_waddr  = 5'd0;
    mem_load   = 1'b0;
    mem_ready  = 1'b0;
    mem_result = 32'd0;
    pipe_flush = 1'b0;
    cmp_y      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clr();
    id_valid = 1'b1;
    id_op    = 6'h04;
    id_rs    = 5'd1;
    ex_wreg  = 1'b1;
    ex_waddr = 5'd1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall got=%h exp=0", stall_id);
    end
    step();
    step();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rv got=%h exp=0", redirect_valid);
    end
    n_cmp++;
    if (redirect_target !== 32'd0) begin
      n_err++;
      $display("FAIL rst_tgt got=%h exp=0", redirect_target);
    end
    resetn = 1'b1;
    clr();
    step();
  endtask

  task automatic test_beq_nohaz();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h04;
    id_rs    = 5'd1;
    id_rt    = 5'd2;
    rf_a     = 32'd5;
    rf_b     = 32'd5;
    id_imm   = 16'h0004;
    id_pc4   = 32'h100;
    cmp_y    = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL beq_stall got=%h exp=0", stall_id);
    end
    n_cmp++;
    if (cmp_op !== 6'h04) begin
      n_err++;
      $display("FAIL beq_op got=%h exp=04", cmp_op);
    end
    n_cmp++;
    if (cmp_a !== 32'd5 || cmp_b !== 32'd5) begin
      n_err++;
      $display("FAIL beq_ab got=%h/%h exp=5/5", cmp_a, cmp_b);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b1) begin
      n_err++;
      $display("FAIL beq_rv got=%h exp=1", redirect_valid);
    end
    n_cmp++;
    if (redirect_target !== 32'h110) begin
      n_err++;
      $display("FAIL beq_tgt got=%h exp=110", redirect_target);
    end
    step();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL beq_pulse got=%h exp=0", redirect_valid);
    end
  endtask

  task automatic test_bne_ex();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h05;
    id_rs    = 5'd1;
    id_rt    = 5'd2;
    rf_a     = 32'd1;
    rf_b     = 32'd7;
    id_pc4   = 32'h200;
    id_imm   = 16'h0010;
    ex_wreg  = 1'b1;
    ex_waddr = 5'd2;
    #1;
    n_cmp++;
    if (stall_id !== 1'b1) begin
      n_err++;
      $display("FAIL bne_stall got=%h exp=1", stall_id);
    end
    step();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bne_wait_rv got=%h exp=0", redirect_valid);
    end
    ex_wreg    = 1'b0;
    mem_wreg   = 1'b1;
    mem_waddr  = 5'd2;
    mem_result = 32'hDEAD;
    cmp_y      = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL bne_go got=%h exp=0", stall_id);
    end
    n_cmp++;
    if (cmp_b !== 32'hDEAD || cmp_a !== 32'd1) begin
      n_err++;
      $display("FAIL bne_fwd got=%h/%h exp=1/dead",
               cmp_a, cmp_b);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_target !== 32'h240) begin
      n_err++;
      $display("FAIL bne_redir got=%h/%h exp=1/240",
               redirect_valid, redirect_target);
    end
  endtask

  task automatic test_bgtz_load();
    clr();
    id_valid   = 1'b1;
    id_op      = 6'h07;
    id_rs      = 5'd3;
    id_rt      = 5'd5;
    ex_wreg    = 1'b1;
    ex_waddr   = 5'd5;
    mem_wreg   = 1'b1;
    mem_waddr  = 5'd3;
    mem_load   = 1'b1;
    mem_result = 32'h42;
    id_pc4     = 32'h300;
    id_imm     = 16'hFFFF;
    cmp_y      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (stall_id !== 1'b1) begin
        n_err++;
        $display("FAIL bgtz_stall%0d got=%h exp=1",
                 i, stall_id);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0 || cmp_a !== 32'h42) begin
      n_err++;
      $display("FAIL bgtz_go got=%h/%h exp=0/42",
               stall_id, cmp_a);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_target !== 32'h2FC) begin
      n_err++;
      $display("FAIL bgtz_redir got=%h/%h exp=1/2fc",
               redirect_valid, redirect_target);
    end
  endtask

  task automatic test_bltz();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h01;
    id_rt_f  = 5'h00;
    id_rs    = 5'd4;
    rf_a     = 32'h8000_0000;
    id_pc4   = 32'h400;
    id_imm   = 16'h0008;
    cmp_y    = 1'b1;
    #1;
    n_cmp++;
    if (cmp_op !== 6'h01 || cmp_rt !== 5'h00 ||
        cmp_a !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL bltz_cmp got=%h/%h/%h exp=01/00/80000000",
               cmp_op, cmp_rt, cmp_a);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_target !== 32'h420) begin
      n_err++;
      $display("FAIL bltz_tk got=%h/%h exp=1/420",
               redirect_valid, redirect_target);
    end
    id_valid = 1'b1;
    id_op    = 6'h01;
    id_rs    = 5'd4;
    id_pc4   = 32'h500;
    id_imm   = 16'h0008;
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b0 ||
        redirect_target !== 32'h420) begin
      n_err++;
      $display("FAIL bltz_nt got=%h/%h exp=0/420",
               redirect_valid, redirect_target);
    end
  endtask

  task automatic test_zero_reg();
    clr();
    id_valid   = 1'b1;
    id_op      = 6'h04;
    ex_wreg    = 1'b1;
    mem_wreg   = 1'b1;
    mem_load   = 1'b1;
    mem_result = 32'h99;
    rf_a       = 32'h11;
    rf_b       = 32'h22;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0 || cmp_a !== 32'h11 ||
        cmp_b !== 32'h22) begin
      n_err++;
      $display("FAIL zero_reg got=%h/%h/%h exp=0/11/22",
               stall_id, cmp_a, cmp_b);
    end
    step();
  endtask

  task automatic test_nonbranch();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h23;
    id_rs    = 5'd1;
    ex_wreg  = 1'b1;
    ex_waddr = 5'd1;
    cmp_y    = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0 || cmp_op !== 6'd0) begin
      n_err++;
      $display("FAIL nb_lw got=%h/%h exp=0/00",
               stall_id, cmp_op);
    end
    id_op   = 6'h01;
    id_rt_f = 5'h02;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0 || cmp_op !== 6'd0) begin
      n_err++;
      $display("FAIL nb_regimm got=%h/%h exp=0/00",
               stall_id, cmp_op);
    end
    step();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL nb_rv got=%h exp=0", redirect_valid);
    end
  endtask

  task automatic enter_wait();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h04;
    id_rs    = 5'd1;
    id_rt    = 5'd2;
    id_pc4   = 32'h800;
    id_imm   = 16'h0001;
    ex_wreg  = 1'b1;
    ex_waddr = 5'd1;
    step();
    ex_wreg  = 1'b0;
    cmp_y    = 1'b1;
  endtask

  task automatic test_flush_wait();
    enter_wait();
    pipe_flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL fl_stall got=%h exp=0", stall_id);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fl_rv got=%h exp=0", redirect_valid);
    end
    step();
  endtask

  task automatic test_reset_wait();
    enter_wait();
    resetn = 1'b0;
    ex_wreg = 1'b1;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL rw_stall got=%h exp=0", stall_id);
    end
    step();
    resetn = 1'b1;
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b0 ||
        redirect_target !== 32'd0) begin
      n_err++;
      $display("FAIL rw_redir got=%h/%h exp=0/0",
               redirect_valid, redirect_target);
    end
    step();
  endtask

  task automatic test_valid_drop();
    enter_wait();
    ex_wreg  = 1'b1;
    id_valid = 1'b0;
    #1;
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL vd_stall got=%h exp=0", stall_id);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL vd_rv got=%h exp=0", redirect_valid);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    id_valid = 1'b1;
    id_op    = 6'h04;
    id_pc4   = 32'h600;
    id_imm   = 16'h0001;
    cmp_y    = 1'b1;
    step();
    id_op    = 6'h05;
    id_pc4   = 32'h700;
    id_imm   = 16'h0002;
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_target !== 32'h604) begin
      n_err++;
      $display("FAIL b2b_1 got=%h/%h exp=1/604",
               redirect_valid, redirect_target);
    end
    step();
    clr();
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_target !== 32'h708) begin
      n_err++;
      $display("FAIL b2b_2 got=%h/%h exp=1/708",
               redirect_valid, redirect_target);
    end
    step();
    n_cmp++;
    if (redirect_valid !== 1'b0 ||
        redirect_target !== 32'h708) begin
      n_err++;
      $display("FAIL b2b_3 got=%h/%h exp=0/708",
               redirect_valid, redirect_target);
    end
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats();
    resetn = 1'b0;
    clr();
    step();
    resetn   = 1'b1;
    id_valid = 1'b1;
    id_op    = 6'h04;
    cmp_y    = 1'b1;
    step();
    id_rs    = 5'd1;
    ex_wreg  = 1'b1;
    ex_waddr = 5'd1;
    step();
    ex_wreg  = 1'b0;
    step();
    id_op     = 6'h07;
    id_rs     = 5'd3;
    mem_wreg  = 1'b1;
    mem_waddr = 5'd3;
    mem_load  = 1'b1;
    cmp_y     = 1'b0;
    step();
    step();
    step();
    mem_ready = 1'b1;
    step();
    clr();
    step();
    n_cmp++;
    if (stat_branches !== 32'd3 || stat_taken !== 32'd2 ||
        stat_stalls !== 32'd4) begin
      n_err++;
      $display("FAIL stats got=%0d/%0d/%0d exp=3/2/4",
               stat_branches, stat_taken, stat_stalls);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    clr();
    test_reset();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    test_beq_nohaz();
    test_bne_ex();
    test_bgtz_load();
    test_bltz();
    test_zero_reg();
    test_nonbranch();
    test_flush_wait();
    test_reset_wait();
    test_valid_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Decode-stage branch resolution controller for the MIPS pipeline.
- Detects RAW hazards on branch operands and stalls ID until operands are ready.
- Selects forwarding sources for the branch comparator and drives the comparator's op/rt/a/b inputs.
- Registers the taken/not-taken outcome and the PC redirect for IF. The delay slot always executes; nothing is flushed.

Parameters:
- DW, 32, datapath width
- RA, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  6  opcode of ID instruction
- id_rt_f  in  5  rt field (REGIMM sub-op)
- id_rs  in  RA  rs register address
- id_rt  in  RA  rt register address
- id_pc4  in  DW  PC+4 of branch
- id_imm  in  16  offset field
- rf_a, rf_b  in  DW  register-file read data
- ex_wreg  in  1  EX writes a register
- ex_waddr  in  RA  EX destination
- mem_wreg  in  1  MEM writes a register
- mem_waddr  in  RA  MEM destination
- mem_load  in  1  MEM holds a load
- mem_ready  in  1  MEM load data valid this cycle
- mem_result  in  DW  MEM-stage result / load data
- pipe_flush  in  1  exception flush
- cmp_y  in  1  comparator result
- cmp_op  out  6  to comparator
- cmp_rt  out  5  to comparator
- cmp_a, cmp_b  out  DW  forwarded operands
- stall_id  out  1  hold IF/ID
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_target  out  DW  branch target

Behaviour:
- is_br: id_valid && op ∈ {BEQ,BNE,BGTZ,BLEZ}, or op==REGIMM && rt_f ∈ {BGEZ,BGEZAL,BLTZ,BLTZAL}.
- use_b only for BEQ/BNE. Register $0 never creates a hazard.
- Hazard on an operand:
  - haz_ex: ex_wreg && ex_waddr==src.
  - Else haz_mem: mem_wreg && mem_waddr==src && mem_load && !mem_ready.
  - EX has priority over MEM.
- Forward select per operand:
  - FWD_MEM when mem_wreg && mem_waddr==src && !haz_ex.
  - Otherwise FWD_RF.
- cmp_op/cmp_rt/cmp_a/cmp_b are combinational from ID fields and the forward selects.
- FSM states:
  - IDLE: if is_br && (any hazard) → WAIT with stall_id=1. If is_br && no hazard → resolve this cycle, stay IDLE, stall_id=0.
  - WAIT: stall_id=1 while any hazard. Resolve in the first cycle with no hazard, stall_id=0 → IDLE.
  - Transitions to WAIT occur at most once per branch. An EX hazard becomes a MEM forward after 1 cycle; a MEM load stalls until mem_ready.
- Resolve cycle: outcome taken = cmp_y. Target = id_pc4 + (sign_ext(id_imm)<<2), mod 2^32.
- Next edge after resolve:
  - redirect_valid ← taken.
  - redirect_target ← target. The register updates only when taken; otherwise it holds its previous value.
- redirect_valid is a single-cycle pulse; it is cleared on the following edge unless another taken branch resolves.
- Latency: hazard-free branch → redirect 1 cycle after ID.
- pipe_flush:
  - Forces state IDLE, stall_id=0, redirect_valid←0 on the next edge.
  - Any pending or resolving branch is discarded.
  - Flush wins over a simultaneous resolve.
- Reset (resetn=0 at edge): state=IDLE, redirect_valid=0, redirect_target=0. Combinational outputs follow inputs and are gated by state (stall_id=0 in reset cycle). Reset mid-WAIT abandons the branch.
- id_valid dropping while in WAIT → IDLE, no redirect.
- Non-branch ID: stall_id=0, cmp_op=0 (comparator yields 0).

Optional Feature:
- BRANCH_RESOLVE_STATS_EN: adds outputs stat_branches, stat_taken, stat_stalls (32-bit each), all saturating at 0xFFFFFFFF.
  - stat_branches/stat_taken increment on resolve.
  - stat_stalls increments each cycle stall_id=1.
  - Counters clear on reset; pipe_flush does not clear them.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Add to the shared defines header: REGIMM opcode, FWD_RF/FWD_MEM select codes, state encodings BR_IDLE/BR_WAIT.
- The branch opcode/rt constants already exist in the header.
- One sub-module: branch_hazard_detect (combinational per-operand hazard + forward select), instantiated twice (rs, rt).

Test Plan:
- BEQ $1,$2, no producers, rf_a=rf_b=5, imm=0x0004, pc4=0x100 → stall 0 cycles; next cycle redirect_valid=1, target=0x110.
- BNE, ex_waddr=$2, ex_wreg=1 → stall_id=1 for 1 cycle; then FWD_MEM on b, cmp_b=mem_result, redirect as cmp_y.
- BGTZ $3, load to $3 in MEM with mem_ready low 3 cycles → stall_id high 3 cycles; resolve on mem_ready=1; imm=0xFFFF → target=pc4-4.
- BLTZ with a=0x80000000 → redirect_valid=1; same with a=0 → no redirect, redirect_target unchanged.
- pipe_flush during WAIT, and resetn=0 during WAIT → IDLE, stall_id=0, no redirect pulse.
- Stats build: 3 branches (2 taken, 4 stall cycles) → 3/2/4; preload near max → counters saturate.
